// File: rtl/dp_alu.sv
// dp_alu: two-cycle ARM data-processing execute stage with NZCV flag register.
module dp_alu (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] shift_out,
   input  logic        shift_carry_out,
   input  logic [3:0]  opcode,
   input  logic        s_bit,
   input  logic        flag_we,
   input  logic [3:0]  flag_din,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        write_rd,
   output logic [3:0]  nzcv,
   output logic        carry_flag
);

   localparam int unsigned DW = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_e;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,
      OP_EOR = 4'd1,
      OP_SUB = 4'd2,
      OP_RSB = 4'd3,
      OP_ADD = 4'd4,
      OP_ADC = 4'd5,
      OP_SBC = 4'd6,
      OP_RSC = 4'd7,
      OP_TST = 4'd8,
      OP_TEQ = 4'd9,
      OP_CMP = 4'd10,
      OP_CMN = 4'd11,
      OP_ORR = 4'd12,
      OP_MOV = 4'd13,
      OP_BIC = 4'd14,
      OP_MVN = 4'd15
   } op_e;

   state_e        state, next_state;
   logic          capture_c;
   logic          finish_c;

   // Operands and controls latched on the IDLE-to-CALC edge
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic          sc_q;
   logic          cin_q;
   logic          s_q;
   op_e           op_q;

   // Combinational ALU outputs evaluated from the latched operands
   logic [DW-1:0] add_x_c;
   logic [DW-1:0] add_y_c;
   logic          add_cin_c;
   logic [DW:0]   sum_c;
   logic          arith_c;
   logic [DW-1:0] res_c;
   logic [3:0]    flags_c;
   logic          flag_en_c;
   logic          wr_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; start is only honoured in IDLE, never queued
   always_comb begin
      next_state = state;
      capture_c  = 1'b0;
      finish_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               capture_c  = 1'b1;
               next_state = ST_CALC;
            end
         end
         ST_CALC: begin
            finish_c   = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Operand capture; carry-in is the flag value before the capture edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sc_q  <= 1'b0;
         cin_q <= 1'b0;
         s_q   <= 1'b0;
         op_q  <= OP_AND;
      end else if (capture_c) begin
         a_q   <= op_a;
         b_q   <= shift_out;
         sc_q  <= shift_carry_out;
         cin_q <= nzcv[1];
         s_q   <= s_bit;
         op_q  <= op_e'(opcode);
      end
   end

   // Adder operand selection: subtracts are expressed as x + ~y + cin
   always_comb begin
      add_x_c   = a_q;
      add_y_c   = b_q;
      add_cin_c = 1'b0;
      arith_c   = 1'b1;
      case (op_q)
         OP_SUB, OP_CMP: begin
            add_y_c   = ~b_q;
            add_cin_c = 1'b1;
         end
         OP_RSB: begin
            add_x_c   = b_q;
            add_y_c   = ~a_q;
            add_cin_c = 1'b1;
         end
         OP_ADD, OP_CMN: begin
            add_cin_c = 1'b0;
         end
         OP_ADC: begin
            add_cin_c = cin_q;
         end
         OP_SBC: begin
            add_y_c   = ~b_q;
            add_cin_c = cin_q;
         end
         OP_RSC: begin
            add_x_c   = b_q;
            add_y_c   = ~a_q;
            add_cin_c = cin_q;
         end
         default: arith_c = 1'b0;
      endcase
   end

   assign sum_c = {1'b0, add_x_c} + {1'b0, add_y_c} + (DW+1)'(add_cin_c);

   // Result mux across arithmetic and logical opcodes
   always_comb begin
      res_c = sum_c[DW-1:0];
      case (op_q)
         OP_AND, OP_TST: res_c = a_q & b_q;
         OP_EOR, OP_TEQ: res_c = a_q ^ b_q;
         OP_ORR:         res_c = a_q | b_q;
         OP_MOV:         res_c = b_q;
         OP_BIC:         res_c = a_q & ~b_q;
         OP_MVN:         res_c = ~b_q;
         default:        res_c = sum_c[DW-1:0];
      endcase
   end

   // New NZCV: logical ops take C from the shifter and keep V
   always_comb begin
      flags_c[3] = res_c[DW-1];
      flags_c[2] = (res_c == '0);
      if (arith_c) begin
         flags_c[1] = sum_c[DW];
         flags_c[0] = (add_x_c[DW-1] == add_y_c[DW-1]) && (sum_c[DW-1] != add_x_c[DW-1]);
      end else begin
         flags_c[1] = sc_q;
         flags_c[0] = nzcv[0];
      end
   end

   // Compare/test opcodes (8..11) always set flags and never write Rd
   assign flag_en_c = s_q || (op_q[3:2] == 2'b10);
   assign wr_c      = (op_q[3:2] != 2'b10);

   // Result, write enable and handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result   <= '0;
         write_rd <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done <= finish_c;
         busy <= (next_state == ST_CALC);
         if (finish_c) begin
            result   <= res_c;
            write_rd <= wr_c;
         end
      end
   end

   // Flag register: ALU update on completion beats a direct load on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nzcv <= 4'b0000;
      end else if (finish_c && flag_en_c) begin
         nzcv <= flags_c;
      end else if (flag_we) begin
         nzcv <= flag_din;
      end
   end

   assign carry_flag = nzcv[1];

endmodule

// File: tb/tb_dp_alu.sv
// tb_dp_alu: directed-vector bench for the dp_alu execute stage.
module tb_dp_alu;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] shift_out;
   logic        shift_carry_out;
   logic [3:0]  opcode;
   logic        s_bit;
   logic        flag_we;
   logic [3:0]  flag_din;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        write_rd;
   logic [3:0]  nzcv;
   logic        carry_flag;

   int n_assert;
   int n_fail;

   dp_alu dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .op_a            (op_a),
      .shift_out       (shift_out),
      .shift_carry_out (shift_carry_out),
      .opcode          (opcode),
      .s_bit           (s_bit),
      .flag_we         (flag_we),
      .flag_din        (flag_din),
      .busy            (busy),
      .done            (done),
      .result          (result),
      .write_rd        (write_rd),
      .nzcv            (nzcv),
      .carry_flag      (carry_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full operation: start for one cycle, check CALC, completion and the idle cycle after
   task automatic run_op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic sc, input logic s,
                         input logic [31:0] exp_res, input logic [3:0] exp_f, input logic exp_wr);
      opcode = opc; op_a = a; shift_out = b; shift_carry_out = sc; s_bit = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_calc_busy"}, 32'(busy), 32'd1);
      check({tag, "_calc_done"}, 32'(done), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done"},     32'(done), 32'd1);
      check({tag, "_busy"},     32'(busy), 32'd0);
      check({tag, "_result"},   result, exp_res);
      check({tag, "_nzcv"},     32'(nzcv), 32'(exp_f));
      check({tag, "_write_rd"}, 32'(write_rd), 32'(exp_wr));
      check({tag, "_carry"},    32'(carry_flag), 32'(exp_f[1]));
      @(posedge clk); #1;
      check({tag, "_done_low"}, 32'(done), 32'd0);
   endtask

   task automatic load_flags(input string tag, input logic [3:0] f);
      flag_we = 1'b1; flag_din = f;
      @(posedge clk); #1;
      flag_we = 1'b0;
      check({tag, "_nzcv"}, 32'(nzcv), 32'(f));
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; op_a = '0; shift_out = '0; shift_carry_out = 1'b0;
      opcode = 4'd0; s_bit = 1'b0; flag_we = 1'b0; flag_din = 4'b0000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset values
      check("rst_result",   result, 32'h0);
      check("rst_nzcv",     32'(nzcv), 32'h0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_done",     32'(done), 32'd0);
      check("rst_write_rd", 32'(write_rd), 32'd0);

      // ADDS signed overflow
      run_op("adds_ovf", 4'd4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 4'b1001, 1'b1);
      // SUBS equal operands: zero, no borrow
      run_op("subs_eq", 4'd2, 32'd5, 32'd5, 1'b0, 1'b1, 32'h0, 4'b0110, 1'b1);
      // CMP 3 vs 5: negative with borrow, no Rd write
      run_op("cmp_lt", 4'd10, 32'd3, 32'd5, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b0);

      // ADC using preloaded carry, flags untouched
      load_flags("pre_c", 4'b0010);
      run_op("adc_cin", 4'd5, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001, 4'b0010, 1'b1);

      // ANDS: C from shifter, V retained
      load_flags("pre_v", 4'b0001);
      run_op("ands", 4'd0, 32'h0000_00F0, 32'h0000_000F, 1'b1, 1'b1, 32'h0, 4'b0111, 1'b1);

      // SBCS with carry set: 10 - 3
      load_flags("pre_c2", 4'b0010);
      run_op("sbcs", 4'd6, 32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 4'b0010, 1'b1);
      // RSBS: 3 - 5 with operands reversed
      run_op("rsbs", 4'd3, 32'd5, 32'd3, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b1);
      // TEQ equal: Z set, C from shifter (0), V kept (0)
      run_op("teq", 4'd9, 32'h55, 32'h55, 1'b0, 1'b0, 32'h0, 4'b0100, 1'b0);
      // MVN without S: flags hold
      run_op("mvn", 4'd15, 32'h1234, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b0100, 1'b1);

      // Start held during CALC is ignored; ALU flags beat flag_we on the completion edge
      opcode = 4'd10; op_a = 32'd3; shift_out = 32'd5; shift_carry_out = 1'b0; s_bit = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      check("busy_calc", 32'(busy), 32'd1);
      flag_we = 1'b1; flag_din = 4'b1111;
      @(posedge clk); #1;
      start = 1'b0; flag_we = 1'b0;
      check("busy_done",   32'(done), 32'd1);
      check("busy_nzcv",   32'(nzcv), 32'(4'b1000));
      check("busy_wr",     32'(write_rd), 32'd0);
      @(posedge clk); #1;
      check("busy_no_requeue_done", 32'(done), 32'd0);
      check("busy_no_requeue_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("busy_idle_done", 32'(done), 32'd0);
      check("busy_idle_busy", 32'(busy), 32'd0);

      // flag_we with start: load lands, operation uses pre-edge carry (0)
      opcode = 4'd5; op_a = 32'd0; shift_out = 32'd0; s_bit = 1'b0; start = 1'b1;
      flag_we = 1'b1; flag_din = 4'b0010;
      @(posedge clk); #1;
      start = 1'b0; flag_we = 1'b0;
      check("we_start_nzcv", 32'(nzcv), 32'(4'b0010));
      @(posedge clk); #1;
      check("we_start_done",   32'(done), 32'd1);
      check("we_start_result", result, 32'h0);
      check("we_start_nzcv2",  32'(nzcv), 32'(4'b0010));
      @(posedge clk); #1;

      // ORRS: C from shifter (0), V kept (0)
      run_op("orrs", 4'd12, 32'hF0, 32'h0F, 1'b0, 1'b1, 32'h0000_00FF, 4'b0000, 1'b1);

      // Reset mid-CALC aborts with no done and cleared state
      load_flags("pre_abort", 4'b1111);
      opcode = 4'd4; op_a = 32'h7FFF_FFFF; shift_out = 32'd1; s_bit = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("abort_busy_pre", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_result", result, 32'h0);
      check("abort_nzcv",   32'(nzcv), 32'h0);
      check("abort_busy",   32'(busy), 32'd0);
      check("abort_done",   32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_done_e1", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("abort_done_e2", 32'(done), 32'd0);
      check("abort_nzcv_e2", 32'(nzcv), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
